// File: rtl/conv3x3_mac.sv
// 3x3 convolution MAC: reads nine coefficients from the kernel store, multiply-
// accumulates them against a latched pixel window, and hands off a clamped pixel.
module conv3x3_mac #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 9,
    parameter int ACC_W  = 21
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [9*PIX_W-1:0]   window,
    output logic                 busy,
    output logic                 coef_en,
    output logic [3:0]           coef_addr,
    input  logic [COEF_W-1:0]    coef_in,
    output logic [ACC_W-1:0]     result,
    output logic [PIX_W-1:0]     pixel_out,
    output logic                 result_valid,
    input  logic                 result_ready
);

    localparam int PROD_W = COEF_W + PIX_W + 1;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((2 ** PIX_W) - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                   state, state_next;
    logic [PIX_W-1:0]         pix [9];
    logic signed [ACC_W-1:0]  acc;
    logic                     tag_v;
    logic [3:0]               tag_idx;
    logic signed [PROD_W-1:0] prod;
    logic [PIX_W-1:0]         clamped;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // DRAIN waits until the tag of the last issued address has retired.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)              state_next = FETCH;
            FETCH:   if (coef_addr == 4'd8)  state_next = DRAIN;
            DRAIN:   if (!tag_v)             state_next = DONE;
            DONE:    if (result_ready)       state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Pixel is zero-extended so it stays non-negative in the signed multiply.
    always_comb begin
        prod = PROD_W'(signed'(coef_in)) * signed'(PROD_W'({1'b0, pix[tag_idx]}));
    end

    always_comb begin
        clamped = acc[PIX_W-1:0];
        if (acc[ACC_W-1])
            clamped = '0;
        else if (acc > PIX_MAX)
            clamped = '1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coef_en      <= 1'b0;
            coef_addr    <= '0;
            acc          <= '0;
            tag_v        <= 1'b0;
            tag_idx      <= '0;
            result       <= '0;
            pixel_out    <= '0;
            result_valid <= 1'b0;
            for (int unsigned k = 0; k < 9; k++)
                pix[k] <= '0;
        end else begin
            tag_v   <= coef_en;
            tag_idx <= coef_addr;
            if (tag_v)
                acc <= acc + ACC_W'(prod);

            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned k = 0; k < 9; k++)
                            pix[k] <= window[k*PIX_W +: PIX_W];
                        acc       <= '0;
                        coef_en   <= 1'b1;
                        coef_addr <= '0;
                    end
                end
                FETCH: begin
                    if (coef_addr == 4'd8) begin
                        coef_en   <= 1'b0;
                        coef_addr <= '0;
                    end else begin
                        coef_addr <= coef_addr + 4'd1;
                    end
                end
                DRAIN: begin
                    if (!tag_v) begin
                        result       <= acc;
                        pixel_out    <= clamped;
                        result_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready)
                        result_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Reader/consumer side of the 3x3 kernel coefficient store.
- On a start request it latches a 3x3 pixel window and drives the store's addr/en port for addresses 0..8.
- It multiply-accumulates each returned signed coefficient with the matching pixel.
- It presents the signed sum plus a clamped 8-bit pixel on a valid/ready output handshake toward the feature-map writer.

Parameters:
- PIX_W, 8, unsigned pixel width.
- COEF_W, 9, signed coefficient width (matches the store's out port).
- ACC_W, 21, signed accumulator/result width; must be ≥ PIX_W+COEF_W+4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request to convolve window; sampled only in IDLE.
- window  in  9*PIX_W  pixel k at bits [PIX_W*k+PIX_W-1 : PIX_W*k]; k = row*3+col, same order as coefficient addresses.
- busy  out  1  high whenever state != IDLE.
- coef_en  out  1  read enable to coefficient store.
- coef_addr  out  4  coefficient address 0..8.
- coef_in  in  COEF_W  signed coefficient; valid one cycle after its addr/en.
- result  out  ACC_W  signed convolution sum.
- pixel_out  out  PIX_W  result clamped to 0..2^PIX_W-1.
- result_valid  out  1  result/pixel_out valid.
- result_ready  in  1  downstream accepts result.

Behaviour:
- Reset (rst=0, async), all registers cleared:
  - state=IDLE, busy=0, coef_en=0, coef_addr=0.
  - result=0, pixel_out=0, result_valid=0.
  - accumulator=0, index counters=0, latched window=0.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - At an edge with start=1: latch window, clear accumulator, set fetch index=0, go FETCH.
  - start=0: stay.
- FETCH:
  - coef_en=1 and coef_addr=fetch index (registered outputs) for 9 consecutive cycles, addresses 0,1,..,8 in order.
  - After the cycle presenting addr 8, go DRAIN.
- Pipeline alignment:
  - A one-cycle-delayed tag (valid bit + index) tracks each issued address.
  - At each edge where the tag is valid, acc <= acc + sext(coef_in) * zext(pix[tag_index]).
  - Product is computed at COEF_W+PIX_W+1 bits signed; the pixel is zero-extended before the signed multiply.
- DRAIN:
  - coef_en=0, coef_addr holds 0.
  - Absorbs the final (addr 8) coefficient.
  - Next edge loads result <= acc (including the addr-8 product), computes pixel_out, sets result_valid=1, goes DONE.
- Latency: result_valid rises at the 11th rising edge after the start-accepting edge, with no backpressure.
- pixel_out clamp:
  - result < 0 → 0.
  - result > 2^PIX_W-1 → 2^PIX_W-1.
  - otherwise result[PIX_W-1:0].
- DONE:
  - result, pixel_out and result_valid are held stable while result_ready=0.
  - At an edge with result_ready=1: result_valid<=0, go IDLE; result/pixel_out keep their last value.
  - A new start is accepted no earlier than the edge after return to IDLE.
- start while busy is ignored (not queued). Changes on window while busy have no effect.
- No overflow is possible at default widths; no wrap or saturation is applied to the accumulator.
- coef_en is never asserted outside FETCH. Exactly 9 reads are issued per job.
- Reset asserted mid-job aborts immediately: no result_valid is produced for the aborted job, coef_en drops asynchronously.

Test Plan:
- Uniform window, all pixels 100, with Laplacian store (0,-1,0,-1,4,-1,0,-1,0):
  - coef_addr sequence 0..8 on 9 consecutive cycles.
  - result_valid at edge 11.
  - result=0, pixel_out=0.
- Center pixel 200, others 0 → result=800, pixel_out=255 (clamp high).
- Pixels k=1,3,5,7 = 50, others 0 → result=-200, pixel_out=0 (clamp low).
- Center 40, neighbors k=1,3,5,7 = 10, corners 255 → result=120, pixel_out=120.
- Backpressure and busy:
  - Hold result_ready=0 for 5 cycles after result_valid: outputs stable.
  - Pulse start during FETCH and during DONE: ignored, no extra coef_en cycles.
  - Assert result_ready: IDLE next edge; a start on that same edge is not accepted.
- Reset mid-job:
  - Drive rst=0 during FETCH at addr 4 → all outputs 0 asynchronously, no result_valid.
  - After release, a new job on the center-200 window still gives result=800.
